// File: rtl/rf_alu_sequencer.sv
// rf_alu_sequencer: command-side initiator for the register-file/ALU datapath.
// Accepts one ALU or load-immediate command at a time. It drives the read
// ports, captures the ALU result, writes it back through the write port and
// returns the written value on a response channel.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// EXEC  | read ports driven, ALU result captured at closing edge
// WB    | write port enabled for exactly one cycle
// RESP  | response held until rsp_ready, then retire
module rf_alu_sequencer #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_kind,
  input  logic [1:0]      cmd_op,
  input  logic [AW-1:0]   cmd_rs1,
  input  logic [AW-1:0]   cmd_rs2,
  input  logic [AW-1:0]   cmd_rd,
  input  logic [DW-1:0]   cmd_imm,
  input  logic [DW-1:0]   alu_result,
  output logic [1:0]      opcode,
  output logic [AW-1:0]   A1,
  output logic [AW-1:0]   A2,
  output logic [AW-1:0]   A3,
  output logic [DW-1:0]   WD3,
  output logic            WE3,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic [AW-1:0]   rsp_rd,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state_q, state_d;

  // The read-port registers double as the captured rs1/rs2/op fields: they
  // are loaded at accept, hold through EXEC and keep their value afterwards.
  logic [1:0]      opcode_q;
  logic [AW-1:0]   a1_q;
  logic [AW-1:0]   a2_q;
  logic [AW-1:0]   a3_q;
  logic [DW-1:0]   wd3_q;
  logic [AW-1:0]   rd_q;
  logic [DW-1:0]   res_q;
  logic [CNTW-1:0] retired_q;

  logic accept_alu;
  logic accept_imm;
  logic exec_done;
  logic retire;

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_d    = state_q;
    accept_alu = 1'b0;
    accept_imm = 1'b0;
    exec_done  = 1'b0;
    retire     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_kind) begin
            accept_imm = 1'b1;
            state_d    = WB;
          end else begin
            accept_alu = 1'b1;
            state_d    = EXEC;
          end
        end
      end
      EXEC: begin
        exec_done = 1'b1;
        state_d   = WB;
      end
      WB: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command capture, read-port drive and result capture.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      opcode_q <= '0;
      a1_q     <= '0;
      a2_q     <= '0;
      rd_q     <= '0;
      res_q    <= '0;
    end else begin
      if (accept_alu) begin
        opcode_q <= cmd_op;
        a1_q     <= cmd_rs1;
        a2_q     <= cmd_rs2;
      end
      if (accept_alu || accept_imm) rd_q <= cmd_rd;
      if (accept_imm)               res_q <= cmd_imm;
      else if (exec_done)           res_q <= alu_result;
    end
  end

  // Write-port address/data, loaded on the edge entering WB so they match
  // rd_q/res_q during WB and then keep their value until the next write.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      a3_q  <= '0;
      wd3_q <= '0;
    end else if (accept_imm) begin
      a3_q  <= cmd_rd;
      wd3_q <= cmd_imm;
    end else if (exec_done) begin
      a3_q  <= rd_q;
      wd3_q <= alu_result;
    end
  end

  // Saturating count of completed commands.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                         retired_q <= '0;
    else if (retire && ~&retired_q)    retired_q <= retired_q + 1'b1;
  end

  // WE3 decodes straight from the state register so an async reset during
  // WB removes the write enable immediately, before any clock edge.
  assign cmd_ready = (state_q == IDLE);
  assign WE3       = (state_q == WB);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = res_q;
  assign rsp_rd    = rd_q;
  assign opcode    = opcode_q;
  assign A1        = a1_q;
  assign A2        = a2_q;
  assign A3        = a3_q;
  assign WD3       = wd3_q;
  assign retired   = retired_q;

endmodule

// File: doc/rf_alu_sequencer.md
Name: rf_alu_sequencer

Overview:
Command-side initiator for the register-file/ALU datapath. It drives the datapath read ports (A1, A2, opcode), samples the ALU result, and writes it back through the write port (A3, WD3, WE3). It accepts ALU or load-immediate commands over a valid/ready handshake. It returns each written value on a valid/ready response channel. It sits between the instruction source and the datapath and is the only driver of the datapath's inputs.

Parameters:
DW, 32, datapath / register width
AW, 5, register address width
CNTW, 16, width of retired-command counter

Ports:
CLK  input  1  clock, rising edge
RSTn  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_kind  input  1  0 = ALU op, 1 = load immediate
cmd_op  input  2  ALU opcode (ALU op only)
cmd_rs1  input  AW  source register 1
cmd_rs2  input  AW  source register 2
cmd_rd  input  AW  destination register
cmd_imm  input  DW  immediate value (load immediate only)
alu_result  input  DW  ALU result from the datapath
opcode  output  2  to ALU
A1  output  AW  to register file read port 1
A2  output  AW  to register file read port 2
A3  output  AW  to register file write address
WD3  output  DW  to register file write data
WE3  output  1  register file write enable
rsp_valid  output  1  response holds the value written
rsp_ready  input  1  consumer accepts response
rsp_data  output  DW  value written to rd
rsp_rd  output  AW  destination register of the response
retired  output  CNTW  count of completed commands, saturating

Behaviour:
- FSM states: IDLE, EXEC, WB, RESP. Reset (RSTn=0, async) forces IDLE and clears all internal registers.
- Reset values: opcode/A1/A2/A3/WD3/rsp_data/rsp_rd/retired = 0; WE3 = 0; rsp_valid = 0.
- cmd_ready = (state==IDLE). It is combinational from state, so it is 1 immediately after reset.
- IDLE: on cmd_valid&&cmd_ready, capture all cmd_* fields.
  - ALU command: go to EXEC.
  - Load immediate: set res_q = cmd_imm and go to WB.
- EXEC (1 cycle):
  - Drive A1 = rs1_q, A2 = rs2_q, opcode = op_q.
  - Register alu_result into res_q at the closing edge.
  - Go to WB.
- WB (1 cycle):
  - Assert WE3 = 1, with A3 = rd_q and WD3 = res_q.
  - The write commits at the closing edge.
  - Go to RESP.
- RESP:
  - rsp_valid = 1, rsp_data = res_q, rsp_rd = rd_q.
  - All three hold stable until rsp_ready.
  - On handshake: retired increments (saturating at all-ones), then go to IDLE.
- Outputs outside their owning state:
  - A1/A2/opcode keep their last driven value.
  - WE3 = 0 in every state except WB.
  - A3/WD3 keep their last value.
- Latency, command accept to rsp_valid: ALU 3 cycles, load immediate 2 cycles (zero rsp_ready stall).
- Throughput: one command in flight. The earliest next accept is the cycle after the response handshake.
- Hazards: a command's write commits before the next command's EXEC, so back-to-back dependent commands read the new value. No forwarding is needed.
- rd = 0 gets no special treatment. Whatever the register file does with address 0 is what is read back.
- Reset mid-operation: return to IDLE immediately. WE3 deasserts asynchronously, so no partial write. Any pending response is discarded and retired is cleared.
- cmd_* fields are ignored when cmd_ready = 0. rsp_ready is ignored when rsp_valid = 0.

Test Plan:
- Reset then LOADI rd=3, imm=0x0000_00A5 -> WE3 pulses exactly 1 cycle with A3=3, WD3=0xA5. rsp_valid 2 cycles after accept, rsp_data=0xA5, rsp_rd=3, retired=1.
- LOADI r1=7, LOADI r2=5, then ALU op=2'b00, rs1=1, rs2=2, rd=4 -> A1=1/A2=2/opcode=00 in EXEC. WB writes the ALU model result for (7,5,00) to r4. rsp_data matches. Latency 3.
- Dependent chain: ALU op on r4 issued immediately after previous response -> EXEC reads the freshly written r4 value. No stale data.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data/rsp_rd stable, cmd_ready=0, WE3=0, no second write. retired increments only on release.
- Assert RSTn=0 during WB of LOADI rd=6, imm=0xDEAD_BEEF -> WE3 drops at once, r6 unchanged, all outputs at reset values, cmd_ready=1 after release.
- Force retired to 0xFFFF (or run 65535 commands), run one more -> retired stays 0xFFFF.
